multi_cycle_sequencer: RTL and testbench
========================================

MULTI_CYCLE_SEQUENCER -- requirements
Module: multi_cycle_sequencer

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the PC and address width.
REQ-002 Parameter RESET_PC, default 0, SHALL set the PC value after reset.
REQ-003 Parameter MAX_WAIT, default 15, SHALL set the maximum cycles to wait for a memory ack.
REQ-004 Parameter CNT_W, default 32, SHALL set the retired-instruction counter width.
REQ-005 clk  in  1  clock; one clock, all state updates on its rising edge.
REQ-006 reset_n  in  1  reset, asynchronous and active-low.
REQ-007 run  in  1  sequencing allowed while high.
REQ-008 imem_req  out  1  instruction fetch request.
REQ-009 imem_addr  out  XLEN  fetch address, equal to pc.
REQ-010 imem_ack  in  1  fetch data valid.
REQ-011 imem_rdata  in  32  fetched instruction.
REQ-012 instr  out  32  latched instruction register.
REQ-013 decode_en, reg_rd_en, alu_en, reg_wr_en  out  1 each  one-cycle stage strobes.
REQ-014 is_branch, mem_access, alu_zero  in  1 each  decoder/ALU status.
REQ-015 branch_target  in  XLEN  taken-branch PC.
REQ-016 dmem_req  out  1  data memory request.
REQ-017 dmem_ack  in  1  data access complete.
REQ-018 pc  out  XLEN  current PC.
REQ-019 retired  out  CNT_W  retired-instruction count.
REQ-020 halted, error  out  1 each  sticky status flags.

Function
REQ-021 FSM states SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR.
REQ-022 IDLE: go to FETCH when run=1; otherwise stay.
REQ-023 FETCH: hold imem_req=1 with a stable imem_addr until imem_ack; on ack, latch imem_rdata into instr.
REQ-024 FETCH exit on ack: go to HALT if the instruction is 0x00000073 (ECALL), otherwise go to DECODE.
REQ-025 DECODE, EXEC, WB: each SHALL last exactly one cycle and pulse decode_en, reg_rd_en+alu_en, and reg_wr_en respectively.
REQ-026 EXEC exit: go to MEM if mem_access=1, otherwise go to WB.
REQ-027 MEM: hold dmem_req=1 until dmem_ack, then go to WB.
REQ-028 PC update in WB: pc <= branch_target if is_branch&&alu_zero, otherwise pc+4 (modulo 2^XLEN, wraps silently).
REQ-029 Retired count in WB: retired SHALL increment, wrapping at 2^CNT_W.
REQ-030 WB exit: go to FETCH if run=1, otherwise go to IDLE.
REQ-031 Minimum latency: 4 cycles per non-memory instruction and 5 for memory, plus wait cycles.
REQ-032 Wait counter: counts cycles in FETCH/MEM without ack.
REQ-033 Timeout: if the wait count reaches MAX_WAIT without ack, the FSM SHALL go to ERR with error=1 and all requests deasserted.
REQ-034 run=0 mid-instruction: the current instruction completes; only the WB exit honours run.
REQ-035 A stray ack outside a pending request SHALL be ignored.
REQ-036 HALT and ERR SHALL be absorbing; only reset exits them.

Reset
REQ-037 reset_n=0 SHALL immediately force: state IDLE, pc=RESET_PC, instr=0, retired=0, all strobes and requests 0, halted=0, error=0, wait counter 0.
REQ-038 Reset asserted mid-request SHALL drop imem_req/dmem_req asynchronously.

Structure
REQ-039 The state enum, the ECALL encoding constant and the PC step constant (4) SHALL live in the shared package rv_pkg.
REQ-040 The wait/timeout counter SHALL be one sub-module, wait_timer, with a clear/count/expired interface.

Verification
REQ-041 Reset, run=1, immediate acks, 0x00500093 fetched, mem_access=0 -> FETCH to WB in 4 cycles; pc 0 -> 4; retired=1.
REQ-042 imem_ack delayed 3 cycles -> imem_req held 4 cycles with imem_addr stable; result otherwise identical to REQ-041.
REQ-043 is_branch=1, alu_zero=1, branch_target=0x40 -> pc=0x40; with alu_zero=0 -> pc=pc+4.
REQ-044 Load with mem_access=1, dmem_ack after 2 cycles -> dmem_req high 3 cycles; 7-cycle instruction.
REQ-045 dmem_ack never arrives, MAX_WAIT=15 -> after 15 wait cycles: error=1, state ERR, dmem_req=0; reset_n low clears error.
REQ-046 ECALL fetched -> halted=1, retired unchanged, no reg_wr_en; pc=RESET_PC+0xFFFFFFFC then WB -> pc wraps to 0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared definitions for the multi-cycle instruction sequencer.
// Latency: none (types and constants only).
// Backpressure: n/a.
package rv_pkg;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT,
    ERR
  } state_e;

  // Fetching this word halts the sequencer instead of decoding it.
  localparam logic [31:0] ECALL_INSN = 32'h0000_0073;

  // Sequential PC increment in bytes.
  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/multi_cycle_sequencer_if.sv
// Instruction and data memory request/ack bus between the sequencer and memories.
// Latency: wires only.
// Backpressure: a request stays asserted until the matching ack is seen.
// Ports: imem_req/imem_addr (master out), imem_ack/imem_rdata (master in),
//        dmem_req (master out), dmem_ack (master in).
interface multi_cycle_sequencer_if #(
  parameter int XLEN = 32
) ();

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            dmem_req;
  logic            dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_req,
    input  imem_ack, imem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req,
    output imem_ack, imem_rdata, dmem_ack
  );

endinterface

// File: rtl/wait_timer.sv
// Counts consecutive cycles spent waiting for a memory ack and flags a timeout.
// Latency: expired is combinational in the cycle the count reaches MAX_WAIT.
// Backpressure: none; clear has priority over count.
// Ports: clk, reset_n, clear (restart from 0), count (one more wait cycle), expired.
module wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The current wait cycle is the MAX_WAIT-th one without an ack.
  assign expired = count && (cnt_q == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/multi_cycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB instruction sequencer with timeout and halt.
// Latency: 4 cycles per instruction, 5 with a data access, plus memory wait cycles.
// Backpressure: imem_req/dmem_req held until ack; no ack within MAX_WAIT cycles -> ERR.
// Ports: clk, reset_n, run, mem (memory bus master), instr, stage strobes
//        (decode_en, reg_rd_en, alu_en, reg_wr_en), decoder/ALU status
//        (is_branch, mem_access, alu_zero, branch_target), pc, retired, halted, error.
module multi_cycle_sequencer
  import rv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              MAX_WAIT = 15,
  parameter int              CNT_W    = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    run,
  multi_cycle_sequencer_if.master mem,
  output logic [31:0]             instr,
  output logic                    decode_en,
  output logic                    reg_rd_en,
  output logic                    alu_en,
  output logic                    reg_wr_en,
  input  logic                    is_branch,
  input  logic                    mem_access,
  input  logic                    alu_zero,
  input  logic [XLEN-1:0]         branch_target,
  output logic [XLEN-1:0]         pc,
  output logic [CNT_W-1:0]        retired,
  output logic                    halted,
  output logic                    error
);

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic tmr_count;
  logic tmr_expired;

  // Only cycles that are still waiting for their ack advance the timer; any
  // other cycle (including the ack cycle itself) restarts it. Acks seen in
  // other states are simply never looked at.
  assign tmr_count = ((state_q == FETCH) && !mem.imem_ack) ||
                     ((state_q == MEM)   && !mem.dmem_ack);

  wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (!tmr_count),
    .count   (tmr_count),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        if (mem.imem_ack) begin
          instr_d = mem.imem_rdata;
          state_d = (mem.imem_rdata == ECALL_INSN) ? HALT : DECODE;
        end else if (tmr_expired) begin
          state_d = ERR;
        end
      end
      DECODE: state_d = EXEC;
      EXEC:   state_d = mem_access ? MEM : WB;
      MEM: begin
        if (mem.dmem_ack) begin
          state_d = WB;
        end else if (tmr_expired) begin
          state_d = ERR;
        end
      end
      WB: begin
        pc_d      = (is_branch && alu_zero) ? branch_target : pc_q + XLEN'(PC_STEP);
        retired_d = retired_q + CNT_W'(1);
        // run is only honoured here, so an instruction in flight always finishes.
        state_d   = run ? FETCH : IDLE;
      end
      HALT:    state_d = HALT;
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  // Requests, strobes and flags decode straight from the state register so
  // reset drops them immediately and HALT/ERR keep them stable.
  assign mem.imem_req  = (state_q == FETCH);
  assign mem.imem_addr = pc_q;
  assign mem.dmem_req  = (state_q == MEM);
  assign decode_en     = (state_q == DECODE);
  assign reg_rd_en     = (state_q == EXEC);
  assign alu_en        = (state_q == EXEC);
  assign reg_wr_en     = (state_q == WB);
  assign halted        = (state_q == HALT);
  assign error         = (state_q == ERR);
  assign instr         = instr_q;
  assign pc            = pc_q;
  assign retired       = retired_q;

endmodule

// File: tb/tb_multi_cycle_sequencer.sv
module tb_multi_cycle_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run;
  logic        is_branch, mem_access, alu_zero;
  logic [31:0] branch_target;
  logic [31:0] instr, pc, retired;
  logic        decode_en, reg_rd_en, alu_en, reg_wr_en, halted, error;

  always #5 clk = ~clk;

  multi_cycle_sequencer_if #(.XLEN(32)) bus ();

  multi_cycle_sequencer #(
    .XLEN(32), .RESET_PC(32'h0), .MAX_WAIT(15), .CNT_W(32)
  ) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .mem(bus),
    .instr(instr), .decode_en(decode_en), .reg_rd_en(reg_rd_en),
    .alu_en(alu_en), .reg_wr_en(reg_wr_en), .is_branch(is_branch),
    .mem_access(mem_access), .alu_zero(alu_zero),
    .branch_target(branch_target), .pc(pc), .retired(retired),
    .halted(halted), .error(error)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    int          cycles;
    int          ireq;
    int          dreq;
    logic [31:0] ret;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_ret;
  logic [31:0] exp_pc;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic bit sig_sel(input int w);
    case (w)
      0:       return bus.imem_req;
      1:       return bus.dmem_req;
      default: return reg_wr_en;
    endcase
  endfunction

  // Waits (bounded) until the selected DUT output is high, sampled 1 time unit after posedge.
  task automatic wait_high(input string name, input int w);
    int n;
    n = 0;
    while (!sig_sel(w) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!sig_sel(w)) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout_%s: got 0 expected 1", name);
    end
  endtask

  // Monitor: tracks each instruction from its first fetch cycle and checks it at WB.
  initial begin : monitor
    bit          busy, moved;
    int          cyc, ic, dc;
    logic [31:0] addr0;
    exp_t        e;
    busy = 0; moved = 0; cyc = 0; ic = 0; dc = 0; addr0 = '0;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        busy = 0;
      end else begin
        if (bus.imem_req && !busy) begin
          busy = 1; cyc = 0; ic = 0; dc = 0; moved = 0; addr0 = bus.imem_addr;
        end
        if (busy) begin
          cyc++;
          if (bus.imem_req) begin
            ic++;
            if (bus.imem_addr !== addr0) moved = 1;
          end
          if (bus.dmem_req) dc++;
        end
        if (reg_wr_en) begin
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_retire: got reg_wr_en=1 expected 0 (pc 0x%0h)", pc);
          end else begin
            e = sb_q.pop_front();
            check("wb_instr", instr, e.instr);
            check("wb_pc", pc, e.pc);
            check("instr_cycles", cyc, e.cycles);
            check("imem_req_cycles", ic, e.ireq);
            check("dmem_req_cycles", dc, e.dreq);
            check("imem_addr_stable", moved, 0);
            check("retired_before_wb", retired, e.ret);
          end
          busy = 0;
        end
      end
    end
  end

  task automatic do_instr(input logic [31:0] insn, input int fd, input bit is_mem,
                          input int md, input bit br, input bit z,
                          input logic [31:0] tgt, input bit stray, input bit drop_run);
    exp_t e;
    e.instr  = insn;
    e.pc     = exp_pc;
    e.ireq   = fd + 1;
    e.dreq   = is_mem ? md + 1 : 0;
    e.cycles = e.ireq + 3 + e.dreq;
    e.ret    = exp_ret;
    sb_q.push_back(e);
    exp_ret++;
    exp_pc = (br && z) ? tgt : exp_pc + 32'd4;

    is_branch = br; alu_zero = z; branch_target = tgt; mem_access = is_mem;
    wait_high("imem_req", 0);
    repeat (fd) begin @(posedge clk); #1; end
    bus.imem_ack = 1'b1; bus.imem_rdata = insn;
    @(posedge clk); #1;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'hDEAD_BEEF;
    if (drop_run) run = 1'b0;
    if (stray) begin
      bus.imem_ack = 1'b1; bus.dmem_ack = 1'b1;
      @(posedge clk); #1;
      bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    end
    if (is_mem) begin
      wait_high("dmem_req", 1);
      repeat (md) begin @(posedge clk); #1; end
      bus.dmem_ack = 1'b1;
      @(posedge clk); #1;
      bus.dmem_ack = 1'b0;
    end
    wait_high("reg_wr_en", 2);
    @(posedge clk); #1;
  endtask

  initial begin : stim
    int          n;
    logic [31:0] pc_hold;
    reset_n = 1'b0; run = 1'b0;
    is_branch = 1'b0; mem_access = 1'b0; alu_zero = 1'b0; branch_target = '0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.dmem_ack = 1'b0;
    exp_ret = 0; exp_pc = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_retired", retired, 32'h0);
    check("rst_flags", {halted, error, bus.imem_req, bus.dmem_req, decode_en, reg_wr_en}, 6'b0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    run = 1'b1;

    // Basic ALU instruction, immediate ack.
    do_instr(32'h0050_0093, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    check("pc_after_first", pc, 32'h4);
    check("retired_after_first", retired, 32'd1);
    // Fetch ack delayed 3 cycles.
    do_instr(32'h00A0_0113, 3, 0, 0, 0, 0, 32'h0, 0, 0);
    check("pc_after_delayed", pc, 32'h8);
    // Taken branch.
    do_instr(32'h0020_8463, 0, 0, 0, 1, 1, 32'h40, 0, 0);
    check("pc_branch_taken", pc, 32'h40);
    // Branch not taken, with stray acks during DECODE.
    do_instr(32'h0020_9463, 0, 0, 0, 1, 0, 32'h80, 1, 0);
    check("pc_branch_not_taken", pc, 32'h44);
    // Load with data ack after 2 wait cycles.
    do_instr(32'h0000_A183, 0, 1, 2, 0, 0, 32'h0, 0, 0);
    check("pc_after_load", pc, 32'h48);
    // Jump to the top of the address space, then wrap to 0; run dropped mid-instruction.
    do_instr(32'h0000_006F, 0, 0, 0, 1, 1, 32'hFFFF_FFFC, 0, 0);
    check("pc_top", pc, 32'hFFFF_FFFC);
    do_instr(32'h0010_0093, 0, 0, 0, 0, 0, 32'h0, 0, 1);
    check("pc_wrap", pc, 32'h0);
    check("retired_7", retired, 32'd7);
    repeat (3) begin @(posedge clk); #1; end
    check("idle_no_fetch", bus.imem_req, 1'b0);
    check("idle_pc_hold", pc, 32'h0);

    // ECALL halts without retiring.
    run = 1'b1; is_branch = 1'b0; mem_access = 1'b0;
    wait_high("imem_req_ecall", 0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_0073;
    @(posedge clk); #1;
    bus.imem_ack = 1'b0;
    check("halted", halted, 1'b1);
    check("halt_instr", instr, 32'h0000_0073);
    bus.imem_ack = 1'b1; bus.dmem_ack = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    check("halt_absorbing", {halted, error, bus.imem_req, bus.dmem_req}, 4'b1000);
    check("halt_retired", retired, 32'd7);
    check("halt_pc", pc, 32'h0);

    // Reset clears the halt.
    reset_n = 1'b0; #1;
    check("rst2_halted", halted, 1'b0);
    check("rst2_instr", instr, 32'h0);
    check("rst2_retired", retired, 32'h0);
    check("scoreboard_empty", sb_q.size(), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_ret = 0; exp_pc = 32'h0;

    // Data ack never arrives -> ERR after 15 wait cycles.
    mem_access = 1'b1;
    wait_high("imem_req_to", 0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_A183;
    @(posedge clk); #1;
    bus.imem_ack = 1'b0;
    wait_high("dmem_req_to", 1);
    n = 0;
    while (bus.dmem_req && n < 40) begin @(posedge clk); #1; n++; end
    check("dmem_wait_cycles", n, 15);
    check("err_flags", {error, halted, bus.dmem_req, bus.imem_req}, 4'b1000);
    repeat (3) begin @(posedge clk); #1; end
    check("err_absorbing", {error, bus.imem_req, reg_wr_en}, 3'b100);
    check("err_retired", retired, 32'h0);
    reset_n = 1'b0; #1;
    check("rst3_error", error, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Reset mid-fetch drops the request without a clock edge.
    mem_access = 1'b0;
    wait_high("imem_req_rst", 0);
    pc_hold = pc;
    #2 reset_n = 1'b0;
    #1;
    check("async_drop_imem_req", bus.imem_req, 1'b0);
    check("async_pc", pc_hold, 32'h0);
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
